// File: rtl/ci_if_cdc_mc.sv
// ci_if_cdc_mc: multi-channel toggle req/ack CDC
// master (i_mclk) to slave (i_sclk) payload handoff
module ci_if_cdc_mc #(
  parameter int NCH  = 4,
  parameter int DW   = 8,
  parameter int SYNC = 2
) (
  input  logic              i_mclk,
  input  logic              i_rst_n,
  input  logic              i_sclk,
  input  logic              i_ena_m,
  input  logic              i_ena_s,
  input  logic [NCH-1:0]    i_req,
  input  logic [NCH*DW-1:0] i_data,
  input  logic [NCH-1:0]    i_ack_en,
  input  logic [NCH-1:0]    i_drop_clr,
  output logic [NCH-1:0]    o_busy,
  output logic [NCH-1:0]    o_rdy,
  output logic [NCH-1:0]    o_drop,
  output logic [NCH-1:0]    o_sen,
  output logic [NCH*DW-1:0] o_sdata
);

  // master domain state
  logic [NCH-1:0]           req_tgl_q, req_tgl_d;
  logic [NCH-1:0][DW-1:0]   hold_q, hold_d;
  logic [NCH-1:0][SYNC-1:0] ack_sync_q, ack_sync_d;
  logic [NCH-1:0]           ack_hist_q, ack_hist_d;
  logic [NCH-1:0]           busy_q, busy_d;
  logic [NCH-1:0]           rdy_q, rdy_d;
  logic [NCH-1:0]           drop_q, drop_d;

  // master domain events
  logic [NCH-1:0]           ack_edge;
  logic [NCH-1:0]           m_free;
  logic [NCH-1:0]           m_acc;
  logic [NCH-1:0]           m_drop;

  // slave domain state
  logic [NCH-1:0][SYNC-1:0] req_sync_q, req_sync_d;
  logic [NCH-1:0]           req_hist_q, req_hist_d;
  logic [NCH-1:0]           ack_tgl_q, ack_tgl_d;
  logic [NCH-1:0]           sen_q, sen_d;
  logic [NCH-1:0][DW-1:0]   sdata_q, sdata_d;
  logic [NCH-1:0]           req_edge;

  // master events: returning ack edge frees the channel same edge
  always_comb begin
    ack_edge = '0;
    for (int c = 0; c < NCH; c++) begin
      ack_edge[c] = ack_sync_q[c][SYNC-1] ^ ack_hist_q[c];
    end
    m_free = ~busy_q | ack_edge;
    m_acc  = i_req & m_free;
    m_drop = i_req & ~m_free;
  end

  // master next state: accept, sync ack, busy/rdy/drop
  always_comb begin
    req_tgl_d  = req_tgl_q;
    hold_d     = hold_q;
    ack_sync_d = ack_sync_q;
    ack_hist_d = ack_hist_q;
    busy_d     = busy_q;
    rdy_d      = rdy_q;
    drop_d     = drop_q;
    if (i_ena_m) begin
      for (int c = 0; c < NCH; c++) begin
        ack_sync_d[c] = {ack_sync_q[c][SYNC-2:0], ack_tgl_q[c]};
        ack_hist_d[c] = ack_sync_q[c][SYNC-1];
        rdy_d[c]      = ack_edge[c] & i_ack_en[c];
        if (m_acc[c]) begin
          req_tgl_d[c] = ~req_tgl_q[c];
          hold_d[c]    = i_data[c*DW +: DW];
        end
        busy_d[c] = req_tgl_d[c] ^ ack_hist_d[c];
        if (m_drop[c]) begin
          drop_d[c] = 1'b1;
        end else if (i_drop_clr[c]) begin
          drop_d[c] = 1'b0;
        end
      end
    end
  end

  // master domain registers
  always_ff @(posedge i_mclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_tgl_q  <= '0;
      hold_q     <= '0;
      ack_sync_q <= '0;
      ack_hist_q <= '0;
      busy_q     <= '0;
      rdy_q      <= '0;
      drop_q     <= '0;
    end else begin
      req_tgl_q  <= req_tgl_d;
      hold_q     <= hold_d;
      ack_sync_q <= ack_sync_d;
      ack_hist_q <= ack_hist_d;
      busy_q     <= busy_d;
      rdy_q      <= rdy_d;
      drop_q     <= drop_d;
    end
  end

  // slave events: synchronised request toggle changed
  always_comb begin
    req_edge = '0;
    for (int c = 0; c < NCH; c++) begin
      req_edge[c] = req_sync_q[c][SYNC-1] ^ req_hist_q[c];
    end
  end

  // slave next state: deliver payload and return ack toggle
  always_comb begin
    req_sync_d = req_sync_q;
    req_hist_d = req_hist_q;
    ack_tgl_d  = ack_tgl_q;
    sen_d      = sen_q;
    sdata_d    = sdata_q;
    if (i_ena_s) begin
      for (int c = 0; c < NCH; c++) begin
        req_sync_d[c] = {req_sync_q[c][SYNC-2:0], req_tgl_q[c]};
        req_hist_d[c] = req_sync_q[c][SYNC-1];
        sen_d[c]      = req_edge[c];
        if (req_edge[c]) begin
          sdata_d[c]   = hold_q[c];
          ack_tgl_d[c] = ~ack_tgl_q[c];
        end
      end
    end
  end

  // slave domain registers
  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_sync_q <= '0;
      req_hist_q <= '0;
      ack_tgl_q  <= '0;
      sen_q      <= '0;
      sdata_q    <= '0;
    end else begin
      req_sync_q <= req_sync_d;
      req_hist_q <= req_hist_d;
      ack_tgl_q  <= ack_tgl_d;
      sen_q      <= sen_d;
      sdata_q    <= sdata_d;
    end
  end

  assign o_busy  = busy_q;
  assign o_rdy   = rdy_q;
  assign o_drop  = drop_q;
  assign o_sen   = sen_q;
  assign o_sdata = sdata_q;

endmodule

// File: tb/tb_ci_if_cdc_mc.sv
// tb_ci_if_cdc_mc: directed checks for ci_if_cdc_mc
// mclk 100 MHz, sclk 25 MHz, NCH=4 DW=8 SYNC=2
module tb_ci_if_cdc_mc;

  logic        i_mclk, i_sclk, i_rst_n;
  logic        i_ena_m, i_ena_s;
  logic [3:0]  i_req, i_ack_en, i_drop_clr;
  logic [31:0] i_data;
  logic [3:0]  o_busy, o_rdy, o_drop, o_sen;
  logic [31:0] o_sdata;

  int tests = 0;
  int fails = 0;

  bit   rand_mode = 0;
  int   mcnt = 0;
  logic [3:0] sen_prev;
  int   hi_en [4];
  logic [7:0] sbq [4][$];
  int   delivered = 0;

  ci_if_cdc_mc #(.NCH(4), .DW(8), .SYNC(2)) dut (
    .i_mclk(i_mclk), .i_rst_n(i_rst_n), .i_sclk(i_sclk),
    .i_ena_m(i_ena_m), .i_ena_s(i_ena_s),
    .i_req(i_req), .i_data(i_data),
    .i_ack_en(i_ack_en), .i_drop_clr(i_drop_clr),
    .o_busy(o_busy), .o_rdy(o_rdy), .o_drop(o_drop),
    .o_sen(o_sen), .o_sdata(o_sdata)
  );

  initial begin
    i_mclk = 0;
    forever #5 i_mclk = ~i_mclk;
  end

  initial begin
    i_sclk = 0;
    forever #20 i_sclk = ~i_sclk;
  end

  // enable duty patterns for the random scenario
  always @(posedge i_mclk) begin
    #1;
    if (rand_mode) begin
      mcnt = (mcnt + 1) % 3;
      i_ena_m = (mcnt == 0);
    end
  end

  always @(posedge i_sclk) begin
    #1;
    if (rand_mode) i_ena_s = ~i_ena_s;
  end

  // delivery monitor: order, exactly-once, pulse width
  always @(posedge i_sclk) begin
    logic en_at;
    logic [7:0] exp;
    en_at = i_ena_s;
    #1;
    if (rand_mode) begin
      for (int c = 0; c < 4; c++) begin
        if (o_sen[c] && !sen_prev[c]) begin
          hi_en[c] = 0;
          tests++;
          if (sbq[c].size() == 0) begin
            fails++;
            $display("FAIL rnd_unexp ch%0d got %h required none", c,
                     o_sdata[c*8 +: 8]);
          end else begin
            exp = sbq[c].pop_front();
            delivered++;
            if (o_sdata[c*8 +: 8] !== exp) begin
              fails++;
              $display("FAIL rnd_data ch%0d got %h required %h", c,
                       o_sdata[c*8 +: 8], exp);
            end
          end
        end else if (o_sen[c] && en_at) begin
          hi_en[c]++;
        end else if (!o_sen[c] && sen_prev[c]) begin
          tests++;
          if (hi_en[c] != 0 || !en_at) begin
            fails++;
            $display("FAIL rnd_width ch%0d extra_en %0d fall_en %0b required 0/1",
                     c, hi_en[c], en_at);
          end
        end
      end
      sen_prev = o_sen;
    end
  end

  task automatic test_reset();
    i_rst_n = 0; i_ena_m = 1; i_ena_s = 1;
    i_req = 0; i_data = 0; i_ack_en = 4'hF; i_drop_clr = 0;
    #12;
    tests++;
    if (o_busy !== 4'h0) begin
      fails++; $display("FAIL rst_busy got %h required 0", o_busy);
    end
    tests++;
    if (o_rdy !== 4'h0) begin
      fails++; $display("FAIL rst_rdy got %h required 0", o_rdy);
    end
    tests++;
    if (o_drop !== 4'h0) begin
      fails++; $display("FAIL rst_drop got %h required 0", o_drop);
    end
    tests++;
    if (o_sen !== 4'h0) begin
      fails++; $display("FAIL rst_sen got %h required 0", o_sen);
    end
    tests++;
    if (o_sdata !== 32'h0) begin
      fails++; $display("FAIL rst_sdata got %h required 0", o_sdata);
    end
    i_rst_n = 1;
    repeat (3) @(posedge i_mclk);
    #1;
  endtask

  task automatic test_single();
    int k, j;
    logic b_at;
    i_data[7:0] = 8'hA5;
    i_req[0] = 1;
    @(posedge i_mclk); #1;
    i_req[0] = 0;
    tests++;
    if (o_busy[0] !== 1'b1) begin
      fails++; $display("FAIL single_busy got %b required 1", o_busy[0]);
    end
    k = 0;
    for (int i = 1; i <= 8 && k == 0; i++) begin
      @(posedge i_sclk); #1;
      if (o_sen[0]) k = i;
    end
    tests++;
    if (k != 3) begin
      fails++; $display("FAIL single_sen_lat got %0d required 3", k);
    end
    tests++;
    if (o_sdata[7:0] !== 8'hA5) begin
      fails++; $display("FAIL single_sdata got %h required a5", o_sdata[7:0]);
    end
    j = 0; b_at = 1'bx;
    for (int i = 1; i <= 8 && j == 0; i++) begin
      @(posedge i_mclk); #1;
      if (o_rdy[0]) begin j = i; b_at = o_busy[0]; end
    end
    tests++;
    if (j != 3) begin
      fails++; $display("FAIL single_rdy_lat got %0d required 3", j);
    end
    tests++;
    if (b_at !== 1'b0) begin
      fails++; $display("FAIL single_busy_clr got %b required 0", b_at);
    end
    @(posedge i_mclk); #1;
    tests++;
    if (o_rdy[0] !== 1'b0) begin
      fails++; $display("FAIL single_rdy_width got %b required 0", o_rdy[0]);
    end
    @(posedge i_sclk); #1;
    tests++;
    if (o_sen[0] !== 1'b0) begin
      fails++; $display("FAIL single_sen_width got %b required 0", o_sen[0]);
    end
  endtask

  task automatic test_noack();
    int k;
    bit rdy_seen;
    i_ack_en[1] = 0;
    i_data[15:8] = 8'h3C;
    i_req[1] = 1;
    @(posedge i_mclk); #1;
    i_req[1] = 0;
    k = 0;
    for (int i = 1; i <= 8 && k == 0; i++) begin
      @(posedge i_sclk); #1;
      if (o_sen[1]) k = i;
    end
    tests++;
    if (k == 0 || o_sdata[15:8] !== 8'h3C) begin
      fails++; $display("FAIL noack_sen seen %0d data %h required 3c", k,
                        o_sdata[15:8]);
    end
    rdy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge i_mclk); #1;
      if (o_rdy[1]) rdy_seen = 1;
    end
    tests++;
    if (o_busy[1] !== 1'b0) begin
      fails++; $display("FAIL noack_busy got %b required 0", o_busy[1]);
    end
    tests++;
    if (rdy_seen) begin
      fails++; $display("FAIL noack_rdy got 1 required 0");
    end
    i_ack_en[1] = 1;
  endtask

  task automatic test_drop();
    int n;
    i_data[23:16] = 8'h77;
    i_req[2] = 1;
    @(posedge i_mclk); #1;
    tests++;
    if (o_busy[2] !== 1'b1) begin
      fails++; $display("FAIL drop_busy got %b required 1", o_busy[2]);
    end
    i_data[23:16] = 8'h99;
    @(posedge i_mclk); #1;
    i_req[2] = 0;
    tests++;
    if (o_drop[2] !== 1'b1) begin
      fails++; $display("FAIL drop_set got %b required 1", o_drop[2]);
    end
    n = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge i_sclk); #1;
      if (o_sen[2]) begin
        n++;
        tests++;
        if (o_sdata[23:16] !== 8'h77) begin
          fails++; $display("FAIL drop_data got %h required 77", o_sdata[23:16]);
        end
      end
    end
    tests++;
    if (n != 1) begin
      fails++; $display("FAIL drop_sen_count got %0d required 1", n);
    end
    tests++;
    if (o_drop[2] !== 1'b1 || o_busy[2] !== 1'b0) begin
      fails++; $display("FAIL drop_sticky drop %b busy %b required 1/0",
                        o_drop[2], o_busy[2]);
    end
    i_drop_clr[2] = 1;
    @(posedge i_mclk); #1;
    i_drop_clr[2] = 0;
    tests++;
    if (o_drop[2] !== 1'b0) begin
      fails++; $display("FAIL drop_clr got %b required 0", o_drop[2]);
    end
    i_req[2] = 1;
    @(posedge i_mclk); #1;
    i_drop_clr[2] = 1;
    @(posedge i_mclk); #1;
    i_req[2] = 0;
    i_drop_clr[2] = 0;
    tests++;
    if (o_drop[2] !== 1'b1) begin
      fails++; $display("FAIL drop_set_wins got %b required 1", o_drop[2]);
    end
    repeat (16) @(posedge i_sclk);
    #1;
    i_drop_clr[2] = 1;
    @(posedge i_mclk); #1;
    i_drop_clr[2] = 0;
  endtask

  task automatic test_all_channels();
    int k, j;
    i_data = 32'h44332211;
    i_req = 4'hF;
    @(posedge i_mclk); #1;
    i_req = 4'h0;
    k = 0;
    for (int i = 1; i <= 8 && k == 0; i++) begin
      @(posedge i_sclk); #1;
      if (o_sen != 4'h0) k = i;
    end
    tests++;
    if (o_sen !== 4'hF) begin
      fails++; $display("FAIL all_sen got %h required f", o_sen);
    end
    tests++;
    if (o_sdata !== 32'h44332211) begin
      fails++; $display("FAIL all_sdata got %h required 44332211", o_sdata);
    end
    j = 0;
    for (int i = 1; i <= 10 && j == 0; i++) begin
      @(posedge i_mclk); #1;
      if (o_rdy != 4'h0) j = i;
    end
    tests++;
    if (o_rdy !== 4'hF) begin
      fails++; $display("FAIL all_rdy got %h required f", o_rdy);
    end
    repeat (4) @(posedge i_sclk);
    #1;
  endtask

  task automatic test_random();
    int c, t;
    logic [7:0] d;
    sen_prev = 4'h0;
    for (int i = 0; i < 4; i++) hi_en[i] = 0;
    rand_mode = 1;
    for (int n = 0; n < 100; n++) begin
      c = $urandom_range(0, 3);
      d = 8'($urandom_range(0, 255));
      t = 0;
      while (o_busy[c] && t < 300) begin
        @(posedge i_mclk); #1; t++;
      end
      i_data[c*8 +: 8] = d;
      i_req[c] = 1;
      t = 0;
      while (!o_busy[c] && t < 300) begin
        @(posedge i_mclk); #1; t++;
      end
      i_req[c] = 0;
      tests++;
      if (!o_busy[c]) begin
        fails++; $display("FAIL rnd_accept ch%0d got 0 required 1", c);
      end else begin
        sbq[c].push_back(d);
      end
    end
    t = 0;
    while (o_busy != 4'h0 && t < 2000) begin
      @(posedge i_mclk); #1; t++;
    end
    repeat (8) @(posedge i_sclk);
    #2;
    rand_mode = 0;
    i_ena_m = 1;
    i_ena_s = 1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (sbq[i].size() != 0) begin
        fails++; $display("FAIL rnd_left ch%0d got %0d required 0", i,
                          sbq[i].size());
      end
    end
    tests++;
    if (delivered != 100) begin
      fails++; $display("FAIL rnd_count got %0d required 100", delivered);
    end
    @(posedge i_mclk); #1;
  endtask

  task automatic test_reset_mid();
    int k;
    bit bad;
    i_data[31:24] = 8'hC3;
    i_req[3] = 1;
    @(posedge i_mclk); #1;
    i_req[3] = 0;
    tests++;
    if (o_busy[3] !== 1'b1) begin
      fails++; $display("FAIL rmid_busy got %b required 1", o_busy[3]);
    end
    @(posedge i_sclk); #5;
    i_rst_n = 0;
    #1;
    tests++;
    if ({o_busy, o_rdy, o_drop, o_sen} !== 16'h0 || o_sdata !== 32'h0) begin
      fails++; $display("FAIL rmid_outs got %h/%h required 0",
                        {o_busy, o_rdy, o_drop, o_sen}, o_sdata);
    end
    #50;
    i_rst_n = 1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge i_sclk); #1;
      if (o_sen[3] || o_rdy[3] || o_busy[3]) bad = 1;
    end
    tests++;
    if (bad) begin
      fails++; $display("FAIL rmid_spurious got 1 required 0");
    end
    i_data[31:24] = 8'h5A;
    i_req[3] = 1;
    @(posedge i_mclk); #1;
    i_req[3] = 0;
    k = 0;
    for (int i = 1; i <= 8 && k == 0; i++) begin
      @(posedge i_sclk); #1;
      if (o_sen[3]) k = i;
    end
    tests++;
    if (k != 3 || o_sdata[31:24] !== 8'h5A) begin
      fails++; $display("FAIL rmid_fresh lat %0d data %h required 3/5a", k,
                        o_sdata[31:24]);
    end
    k = 0;
    for (int i = 1; i <= 8 && k == 0; i++) begin
      @(posedge i_mclk); #1;
      if (o_rdy[3]) k = i;
    end
    tests++;
    if (k != 3) begin
      fails++; $display("FAIL rmid_rdy got %0d required 3", k);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_noack();
    test_drop();
    test_all_channels();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
